// File: rtl/branch_resolve.sv
// Resolves 8086 Jcc / LOOPcc / JCXZ transfers from a captured flag word.
// Operands are snapshotted on acceptance; results are presented with a one-cycle done pulse.
module branch_resolve #(
  parameter bit EARLY_JCC = 1'b0
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic [1:0]  iKind,
  input  logic [3:0]  iCond,
  input  logic [1:0]  iLoopSel,
  input  logic [15:0] iFlags,
  input  logic [15:0] iCX,
  input  logic [15:0] iIP,
  input  logic [7:0]  iDisp,
  output logic        oBusy,
  output logic        oDone,
  output logic        oTaken,
  output logic [15:0] oNewIP,
  output logic        oCXWr,
  output logic [15:0] oCX
);

  localparam int unsigned W_DATA = 16;
  localparam int unsigned W_DISP = 8;

  localparam logic [1:0] KIND_JCC  = 2'd0;
  localparam logic [1:0] KIND_LOOP = 2'd1;
  localparam logic [1:0] KIND_JCXZ = 2'd2;

  localparam logic [1:0] SEL_LOOPNZ = 2'd0;
  localparam logic [1:0] SEL_LOOPZ  = 2'd1;
  localparam logic [1:0] SEL_LOOP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          kind_q, kind_d;
  logic [3:0]          cond_q, cond_d;
  logic [1:0]          sel_q, sel_d;
  logic                of_q, of_d, sf_q, sf_d, zf_q, zf_d, pf_q, pf_d, cf_q, cf_d;
  logic [W_DATA-1:0]   cx_q, cx_d;
  logic [W_DATA-1:0]   ip_q, ip_d;
  logic [W_DISP-1:0]   disp_q, disp_d;
  logic [W_DATA-1:0]   cx_dec_q, cx_dec_d;
  logic                wr_pend_q, wr_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                taken_q, taken_d;
  logic [W_DATA-1:0]   new_ip_q, new_ip_d;
  logic                cxwr_q, cxwr_d;
  logic [W_DATA-1:0]   cx_out_q, cx_out_d;

  logic                jcc_base_c;
  logic                res_taken_c;
  logic                res_wr_c;
  logic [W_DATA-1:0]   res_ip_c;
  logic                unused_flags_c;

  assign unused_flags_c = ^{iFlags[15:12], iFlags[10:8], iFlags[5:3], iFlags[1]};

  // Condition evaluation on the captured operands.
  always_comb begin
    jcc_base_c  = 1'b0;
    res_taken_c = 1'b0;
    res_wr_c    = 1'b0;
    unique case (cond_q[3:1])
      3'd0: jcc_base_c = of_q;
      3'd1: jcc_base_c = cf_q;
      3'd2: jcc_base_c = zf_q;
      3'd3: jcc_base_c = cf_q | zf_q;
      3'd4: jcc_base_c = sf_q;
      3'd5: jcc_base_c = pf_q;
      3'd6: jcc_base_c = sf_q ^ of_q;
      3'd7: jcc_base_c = (sf_q ^ of_q) | zf_q;
    endcase
    case (kind_q)
      KIND_JCC: res_taken_c = jcc_base_c ^ cond_q[0];
      KIND_LOOP: begin
        case (sel_q)
          SEL_LOOPNZ: begin
            res_wr_c    = 1'b1;
            res_taken_c = (cx_dec_q != '0) & ~zf_q;
          end
          SEL_LOOPZ: begin
            res_wr_c    = 1'b1;
            res_taken_c = (cx_dec_q != '0) & zf_q;
          end
          SEL_LOOP: begin
            res_wr_c    = 1'b1;
            res_taken_c = (cx_dec_q != '0);
          end
          default: ;
        endcase
      end
      KIND_JCXZ: res_taken_c = (cx_q == '0);
      default: ;
    endcase
    res_ip_c = res_taken_c
             ? W_DATA'(ip_q + {{(W_DATA-W_DISP){disp_q[W_DISP-1]}}, disp_q})
             : ip_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cond_d    = cond_q;
    sel_d     = sel_q;
    of_d      = of_q;
    sf_d      = sf_q;
    zf_d      = zf_q;
    pf_d      = pf_q;
    cf_d      = cf_q;
    cx_d      = cx_q;
    ip_d      = ip_q;
    disp_d    = disp_q;
    cx_dec_d  = cx_dec_q;
    wr_pend_d = wr_pend_q;
    taken_d   = taken_q;
    new_ip_d  = new_ip_q;
    cx_out_d  = cx_out_q;
    done_d    = 1'b0;
    cxwr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iReq) begin
          kind_d  = iKind;
          cond_d  = iCond;
          sel_d   = iLoopSel;
          of_d    = iFlags[11];
          sf_d    = iFlags[7];
          zf_d    = iFlags[6];
          pf_d    = iFlags[2];
          cf_d    = iFlags[0];
          cx_d    = iCX;
          ip_d    = iIP;
          disp_d  = iDisp;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        cx_dec_d = W_DATA'(cx_q - W_DATA'(1));
        // Jcc never needs cx_dec, so it may resolve straight from CAPT.
        if (EARLY_JCC && (kind_q == KIND_JCC)) begin
          taken_d   = res_taken_c;
          new_ip_d  = res_ip_c;
          wr_pend_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d   = res_taken_c;
        new_ip_d  = res_ip_c;
        wr_pend_d = res_wr_c;
        if (res_wr_c) begin
          cx_out_d = cx_dec_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d    = 1'b1;
        cxwr_d    = wr_pend_q;
        wr_pend_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      kind_q    <= '0;
      cond_q    <= '0;
      sel_q     <= '0;
      of_q      <= 1'b0;
      sf_q      <= 1'b0;
      zf_q      <= 1'b0;
      pf_q      <= 1'b0;
      cf_q      <= 1'b0;
      cx_q      <= '0;
      ip_q      <= '0;
      disp_q    <= '0;
      cx_dec_q  <= '0;
      wr_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      new_ip_q  <= '0;
      cxwr_q    <= 1'b0;
      cx_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cond_q    <= cond_d;
      sel_q     <= sel_d;
      of_q      <= of_d;
      sf_q      <= sf_d;
      zf_q      <= zf_d;
      pf_q      <= pf_d;
      cf_q      <= cf_d;
      cx_q      <= cx_d;
      ip_q      <= ip_d;
      disp_q    <= disp_d;
      cx_dec_q  <= cx_dec_d;
      wr_pend_q <= wr_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
      new_ip_q  <= new_ip_d;
      cxwr_q    <= cxwr_d;
      cx_out_q  <= cx_out_d;
    end
  end

  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oTaken = taken_q;
  assign oNewIP = new_ip_q;
  assign oCXWr  = cxwr_q;
  assign oCX    = cx_out_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: two instances (EARLY_JCC=0 and =1) share stimulus,
// expected results come from a flag-rule reference model and are checked by a monitor.
module tb_branch_resolve;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iReq = 1'b0;
  logic [1:0]  iKind = '0;
  logic [3:0]  iCond = '0;
  logic [1:0]  iLoopSel = '0;
  logic [15:0] iFlags = '0;
  logic [15:0] iCX = '0;
  logic [15:0] iIP = '0;
  logic [7:0]  iDisp = '0;

  logic        busy0, done0, taken0, cxwr0;
  logic [15:0] nip0, cx0;
  logic        busy1, done1, taken1, cxwr1;
  logic [15:0] nip1, cx1;

  typedef struct {
    bit        taken;
    bit [15:0] ip;
    bit        cxwr;
    bit [15:0] cx;
    int        lat;
    int        acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit        hold_pend[2];
  bit        last_taken[2];
  bit [15:0] last_ip[2];

  branch_resolve #(.EARLY_JCC(1'b0)) dut0 (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iKind(iKind), .iCond(iCond),
    .iLoopSel(iLoopSel), .iFlags(iFlags), .iCX(iCX), .iIP(iIP), .iDisp(iDisp),
    .oBusy(busy0), .oDone(done0), .oTaken(taken0), .oNewIP(nip0),
    .oCXWr(cxwr0), .oCX(cx0)
  );

  branch_resolve #(.EARLY_JCC(1'b1)) dut1 (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iKind(iKind), .iCond(iCond),
    .iLoopSel(iLoopSel), .iFlags(iFlags), .iCX(iCX), .iIP(iIP), .iDisp(iDisp),
    .oBusy(busy1), .oDone(done1), .oTaken(taken1), .oNewIP(nip1),
    .oCXWr(cxwr1), .oCX(cx1)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  // Architectural meaning of each instruction, independent of any state machine.
  function automatic exp_t ref_model(input logic [1:0] kind, input logic [3:0] cond,
                                     input logic [1:0] sel, input logic [15:0] flags,
                                     input logic [15:0] cx, input logic [15:0] ip,
                                     input logic [7:0] disp);
    exp_t e;
    bit of, sf, zf, pf, cf;
    bit [7:0] tbl;
    bit [2:0] pair;
    int cxd;
    of = flags[11]; sf = flags[7]; zf = flags[6]; pf = flags[2]; cf = flags[0];
    tbl = {(sf ^ of) | zf, sf ^ of, pf, sf, cf | zf, zf, cf, of};
    pair = cond[3:1];
    cxd = (int'(cx) + 65535) % 65536;
    e.taken = 1'b0;
    e.cxwr = 1'b0;
    if (kind == 2'd0) begin
      e.taken = tbl[pair] ^ cond[0];
    end else if (kind == 2'd1 && sel != 2'd3) begin
      e.cxwr = 1'b1;
      e.taken = (cxd != 0) && (sel == 2'd2 || (sel == 2'd1 && zf) || (sel == 2'd0 && !zf));
    end else if (kind == 2'd2) begin
      e.taken = (cx == 16'h0000);
    end
    e.ip = e.taken ? 16'((int'(ip) + int'($signed(disp))) & 32'hFFFF) : ip;
    e.cx = 16'(cxd);
    e.lat = 3;
    e.acc = 0;
    return e;
  endfunction

  task automatic check_done(input int id, input exp_t e, input logic taken,
                            input logic [15:0] nip, input logic cxwr, input logic [15:0] cx);
    checks++;
    if (taken !== e.taken) begin
      errors++; $display("FAIL taken dut%0d: got %0b want %0b", id, taken, e.taken);
    end
    checks++;
    if (nip !== e.ip) begin
      errors++; $display("FAIL new_ip dut%0d: got %h want %h", id, nip, e.ip);
    end
    checks++;
    if (cxwr !== e.cxwr) begin
      errors++; $display("FAIL cxwr dut%0d: got %0b want %0b", id, cxwr, e.cxwr);
    end
    if (e.cxwr) begin
      checks++;
      if (cx !== e.cx) begin
        errors++; $display("FAIL cx dut%0d: got %h want %h", id, cx, e.cx);
      end
    end
    checks++;
    if (cyc - e.acc != e.lat) begin
      errors++; $display("FAIL latency dut%0d: got %0d want %0d", id, cyc - e.acc, e.lat);
    end
  endtask

  task automatic mon(input int id, input logic done, input logic taken,
                     input logic [15:0] nip, input logic cxwr, input logic [15:0] cx);
    exp_t e;
    if (iRst) begin
      hold_pend[id] = 1'b0;
      return;
    end
    checks++;
    if (cxwr && !done) begin
      errors++; $display("FAIL cxwr_without_done dut%0d: cxwr=%0b done=%0b", id, cxwr, done);
    end
    if (hold_pend[id]) begin
      hold_pend[id] = 1'b0;
      checks++;
      if (done !== 1'b0 || taken !== last_taken[id] || nip !== last_ip[id]) begin
        errors++;
        $display("FAIL hold dut%0d: done=%0b taken=%0b ip=%h want done=0 taken=%0b ip=%h",
                 id, done, taken, nip, last_taken[id], last_ip[id]);
      end
    end
    if (done) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_done dut%0d: got done=1 want no done", id);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check_done(id, e, taken, nip, cxwr, cx);
        hold_pend[id] = 1'b1;
        last_taken[id] = e.taken;
        last_ip[id] = e.ip;
      end
    end
  endtask

  always @(negedge iClk) begin
    mon(0, done0, taken0, nip0, cxwr0, cx0);
    mon(1, done1, taken1, nip1, cxwr1, cx1);
  end

  task automatic issue(input logic [1:0] kind, input logic [3:0] cond, input logic [1:0] sel,
                       input logic [15:0] flags, input logic [15:0] cx, input logic [15:0] ip,
                       input logic [7:0] disp, input bit noise);
    exp_t e;
    int acc;
    bit ok;
    iKind = kind; iCond = cond; iLoopSel = sel; iFlags = flags;
    iCX = cx; iIP = ip; iDisp = disp; iReq = 1'b1;
    e = ref_model(kind, cond, sel, flags, cx, ip, disp);
    @(posedge iClk); #1;
    acc = cyc;
    e.acc = acc;
    e.lat = 3;
    q0.push_back(e);
    e.lat = (kind == 2'd0) ? 2 : 3;
    q1.push_back(e);
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept: got %0b%0b want 11", busy0, busy1);
    end
    if (noise) begin
      // Scramble operands and keep requesting while both instances are still busy.
      repeat (2) begin
        iKind = 2'($urandom); iCond = 4'($urandom); iLoopSel = 2'($urandom);
        iFlags = 16'($urandom); iCX = 16'($urandom); iIP = 16'($urandom);
        iDisp = 8'($urandom);
        @(posedge iClk); #1;
      end
    end
    iReq = 1'b0;
    iFlags = 16'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge iClk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: pending %0d/%0d want 0/0", q0.size(), q1.size());
      q0.delete(); q1.delete();
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL busy_after_done: got %0b%0b want 00", busy0, busy1);
    end
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #1;
    checks++;
    if ({busy0, done0, taken0, nip0, cxwr0, cx0} !== '0 ||
        {busy1, done1, taken1, nip1, cxwr1, cx1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h want 0", {busy0, done0, taken0, nip0, cxwr0, cx0},
               {busy1, done1, taken1, nip1, cxwr1, cx1});
    end
    iRst = 1'b0;
    @(posedge iClk); #1;

    issue(2'd0, 4'h4, 2'd0, 16'h0040, 16'h1234, 16'h1000, 8'hFE, 1'b0);
    issue(2'd0, 4'hC, 2'd0, 16'h0880, 16'h0000, 16'h2000, 8'h10, 1'b0);
    issue(2'd0, 4'hD, 2'd0, 16'h0880, 16'h0000, 16'h2000, 8'h10, 1'b0);
    issue(2'd1, 4'h0, 2'd2, 16'h0000, 16'h0001, 16'h3000, 8'h10, 1'b0);
    issue(2'd1, 4'h0, 2'd0, 16'h0000, 16'h0000, 16'h3000, 8'h80, 1'b0);
    issue(2'd1, 4'h0, 2'd0, 16'h0040, 16'h0000, 16'h3000, 8'h80, 1'b0);
    issue(2'd2, 4'h0, 2'd0, 16'h0000, 16'h0000, 16'hFFF0, 8'h20, 1'b0);
    issue(2'd3, 4'h5, 2'd1, 16'hFFFF, 16'h0005, 16'h4000, 8'h7F, 1'b0);
    issue(2'd1, 4'h0, 2'd3, 16'hFFFF, 16'h0005, 16'h4000, 8'h7F, 1'b0);
    issue(2'd0, 4'h4, 2'd0, 16'h0040, 16'h0000, 16'h5000, 8'h04, 1'b1);
    issue(2'd1, 4'h0, 2'd1, 16'h0040, 16'h0003, 16'h5000, 8'hF0, 1'b1);

    // Abort a LOOP request in EVAL with reset; nothing is queued so any done is flagged.
    iKind = 2'd1; iLoopSel = 2'd2; iCX = 16'h0010; iIP = 16'h6000; iDisp = 8'h08;
    iReq = 1'b1;
    @(posedge iClk); #1;
    iReq = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    repeat (5) @(posedge iClk);
    #1;
    checks++;
    if ({busy0, taken0, nip0, cx0} !== '0 || {busy1, taken1, nip1, cx1} !== '0) begin
      errors++; $display("FAIL abort_outputs: got %h %h want 0",
                         {busy0, taken0, nip0, cx0}, {busy1, taken1, nip1, cx1});
    end
    issue(2'd1, 4'h0, 2'd2, 16'h0000, 16'h0010, 16'h6000, 8'h08, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [15:0] rcx;
      rcx = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      issue(2'($urandom), 4'($urandom), 2'($urandom), 16'($urandom), rcx,
            16'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    @(posedge iClk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
